flash_boot_loader: RTL
======================

FLASH_BOOT_LOADER -- requirements
Module: flash_boot_loader

Interface
REQ-001 SHALL have parameter WORD_COUNT, default 1024, number of instruction words copied (legal 1..1024).
REQ-002 SHALL have parameter BASE_ADDRESS, default 0, RAM destination of word 0 (legal 0..1023).
REQ-003 SHALL have parameter AUTO_START, default 1, 1 = begin copy automatically after reset release.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, per the ports below.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 async_rst  input  1  asynchronous active-high reset.
REQ-007 Start  input  1  request a copy; sampled only in IDLE or DONE.
REQ-008 ROMAddress  output  10  address to flash instruction ROM.
REQ-009 ROMValue  input  16  ROM word, combinational from ROMAddress, same cycle.
REQ-010 RAMWriteValid  output  1  write request to instruction RAM.
REQ-011 RAMWriteReady  input  1  RAM accepts write when high with RAMWriteValid.
REQ-012 RAMWriteAddress  output  10  RAM word address.
REQ-013 RAMWriteData  output  16  RAM word data.
REQ-014 Busy  output  1  high while copying.
REQ-015 Done  output  1  sticky, high after a complete copy.
REQ-016 CPUHalt  output  1  holds core in halt until copy complete.
REQ-017 Checksum  output  16  running sum of words written.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, WRITE, DONE; internal word index I, 0..WORD_COUNT-1.
REQ-019 IDLE: Start=1 (or AUTO_START=1, first edge after reset release) -> FETCH; I=0; Checksum cleared.
REQ-020 FETCH (one cycle): ROMAddress=I; ROMValue registered into RAMWriteData at edge; -> WRITE.
REQ-021 WRITE: RAMWriteValid=1; RAMWriteAddress=(BASE_ADDRESS+I) mod 1024; handshake = Valid&Ready at edge.
REQ-022 Valid, RAMWriteAddress, RAMWriteData SHALL hold stable until handshake; no Valid drop without handshake.
REQ-023 On handshake: Checksum += RAMWriteData mod 2^16; if I==WORD_COUNT-1 -> DONE else I+=1, -> FETCH.
REQ-024 Exactly one handshake per word; no duplicate or skipped addresses.
REQ-025 Throughput with Ready tied high: 2 cycles/word; Busy high exactly 2*WORD_COUNT cycles.
REQ-026 Busy=1 in FETCH and WRITE only; RAMWriteValid=1 in WRITE only.
REQ-027 DONE: Done=1, CPUHalt=0, Busy=0, Checksum frozen; Done rises the cycle after final handshake.
REQ-028 Start in FETCH/WRITE SHALL be ignored.
REQ-029 Start in DONE SHALL restart: Done=0, CPUHalt=1, Checksum=0, I=0, -> FETCH.
REQ-030 RAMWriteAddress wraps 1023 -> 0; ROMAddress never exceeds WORD_COUNT-1.
REQ-031 AUTO_START=0: SHALL remain in IDLE indefinitely with CPUHalt=1 until Start.

Reset
REQ-032 async_rst=1 SHALL immediately force: state IDLE, I=0, ROMAddress=0, RAMWriteValid=0, RAMWriteAddress=BASE_ADDRESS, RAMWriteData=0, Busy=0, Done=0, CPUHalt=1, Checksum=0.
REQ-033 Reset mid-copy SHALL abort without further writes; copy restarts from word 0 per REQ-019.

Verification
REQ-034 AUTO_START=1, WORD_COUNT=34, Ready=1, current ROM image -> 34 writes addr 0..33, addr 0 data 16'hD188, addr 33 data 16'hA00F, Busy 68 cycles, Checksum = 16-bit sum of image words 0..33.
REQ-035 Ready low 3 cycles during word 5 -> Valid, addr 5, data stable throughout; single write of word 5; Busy lengthened by 3 cycles.
REQ-036 BASE_ADDRESS=1020, WORD_COUNT=8 -> RAM addresses 1020,1021,1022,1023,0,1,2,3; ROM addresses 0..7.
REQ-037 async_rst pulsed while writing word 10 -> Valid low same cycle, CPUHalt=1, Done=0, Checksum=0; after release copy restarts at ROM addr 0.
REQ-038 AUTO_START=0 -> no Valid for 100 cycles; Start pulse -> copy; Start pulses while Busy ignored; Start in DONE repeats copy with identical Checksum.
REQ-039 WORD_COUNT=1 -> one write (addr BASE_ADDRESS, data 16'hD188), Busy 2 cycles, Done next cycle.

Source files
------------

// File: rtl/flash_boot_loader.sv
// Boot loader: copies WORD_COUNT words from flash ROM into instruction RAM and
// keeps the CPU halted until the copy completes, accumulating a 16-bit checksum.
module flash_boot_loader #(
  parameter int unsigned WORD_COUNT   = 1024,
  parameter int unsigned BASE_ADDRESS = 0,
  parameter int unsigned AUTO_START   = 1
) (
  input  logic        clk,
  input  logic        async_rst,
  input  logic        Start,
  output logic [9:0]  ROMAddress,
  input  logic [15:0] ROMValue,
  output logic        RAMWriteValid,
  input  logic        RAMWriteReady,
  output logic [9:0]  RAMWriteAddress,
  output logic [15:0] RAMWriteData,
  output logic        Busy,
  output logic        Done,
  output logic        CPUHalt,
  output logic [15:0] Checksum
);

  localparam logic [9:0] LastIdx  = 10'(WORD_COUNT - 1);
  localparam logic [9:0] BaseAddr = 10'(BASE_ADDRESS);

  typedef enum logic [1:0] {StIdle, StFetch, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic [9:0]  idx_q, idx_d;
  logic [15:0] data_q, data_d;
  logic [15:0] csum_q, csum_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    csum_d  = csum_q;
    case (state_q)
      StIdle: begin
        // IDLE is only reachable through reset, so AUTO_START acts on the first edge after release
        if (Start || (AUTO_START != 0)) begin
          state_d = StFetch;
          idx_d   = '0;
          csum_d  = '0;
        end
      end
      StFetch: begin
        data_d  = ROMValue;
        state_d = StWrite;
      end
      StWrite: begin
        if (RAMWriteReady) begin
          csum_d = csum_q + data_q;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 10'd1;
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        if (Start) begin
          state_d = StFetch;
          idx_d   = '0;
          csum_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      data_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      csum_q  <= csum_d;
    end
  end

  // Address wraps naturally in 10 bits
  assign ROMAddress      = idx_q;
  assign RAMWriteAddress = BaseAddr + idx_q;
  assign RAMWriteData    = data_q;
  assign RAMWriteValid   = (state_q == StWrite);
  assign Busy            = (state_q == StFetch) || (state_q == StWrite);
  assign Done            = (state_q == StDone);
  assign CPUHalt         = (state_q != StDone);
  assign Checksum        = csum_q;

endmodule
